// File: rtl/pla_sweep_pkg.sv
// rtl/pla_sweep_pkg.sv - shared types and defaults for the PLA sweep controller
// Contents: sweep FSM state encoding, default MISR polynomial and seed.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
  localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

endpackage

// File: rtl/pla_sweep_ctrl_if.sv
// rtl/pla_sweep_ctrl_if.sv - control/result bundle between sweep controller and harness
// Signals:
//   start, abort       harness -> ctrl  sweep control levels
//   vec_o              ctrl -> harness  vector driven onto both function instances
//   dut_y_i, ref_y_i   harness -> ctrl  DUT and golden function outputs
//   busy, done         ctrl -> harness  sweep status
//   onset_cnt, mismatch_cnt, first_mm_vec, first_mm_valid, signature
//                      ctrl -> harness  accumulated results
// Modports: master = harness side, slave = controller side.
interface pla_sweep_ctrl_if #(
  parameter int N_IN  = 9,
  parameter int SIG_W = 16
) ();

  logic              start;
  logic              abort;
  logic [N_IN-1:0]   vec_o;
  logic              dut_y_i;
  logic              ref_y_i;
  logic              busy;
  logic              done;
  logic [N_IN:0]     onset_cnt;
  logic [N_IN:0]     mismatch_cnt;
  logic [N_IN-1:0]   first_mm_vec;
  logic              first_mm_valid;
  logic [SIG_W-1:0]  signature;

  modport master (
    output start, abort, dut_y_i, ref_y_i,
    input  vec_o, busy, done, onset_cnt, mismatch_cnt,
           first_mm_vec, first_mm_valid, signature
  );

  modport slave (
    input  start, abort, dut_y_i, ref_y_i,
    output vec_o, busy, done, onset_cnt, mismatch_cnt,
           first_mm_vec, first_mm_valid, signature
  );

endinterface

// File: rtl/pla_misr.sv
// rtl/pla_misr.sv - single-input signature register over the DUT function output
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (loads SIG_SEED)
//   clear       load SIG_SEED (wins over enable)
//   enable      shift one bit of data_in into the signature
//   data_in     serial input bit, folded into bit 0
//   sig_out     current signature
module pla_misr
  import pla_sweep_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             data_in,
  output logic [SIG_W-1:0] sig_out
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_nxt;

  // Galois-style step: shift left, fold the polynomial when the MSB falls
  // out, then fold the new data bit into bit 0.
  always_comb begin
    sig_nxt = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
            ^ {{(SIG_W-1){1'b0}}, data_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SIG_SEED;
    end else if (clear) begin
      sig_q <= SIG_SEED;
    end else if (enable) begin
      sig_q <= sig_nxt;
    end
  end

  assign sig_out = sig_q;

endmodule

// File: rtl/pla_sweep_ctrl.sv
// rtl/pla_sweep_ctrl.sv - exhaustive input sweep and equivalence accumulator for PLA functions
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pla_sweep_ctrl_if.slave: start/abort in, vec_o out, dut_y_i/ref_y_i in,
//          busy/done and onset/mismatch/first-mismatch/signature results out
// Each vector is held for SETTLE cycles in SETTLE, then sampled for one cycle
// in SAMPLE, giving SETTLE+1 cycles per vector over all 2^N_IN vectors.
module pla_sweep_ctrl
  import pla_sweep_pkg::*;
#(
  parameter int               N_IN     = 9,
  parameter int               SETTLE   = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
  input logic              clk,
  input logic              rst_n,
  pla_sweep_ctrl_if.slave  bus
);

  localparam int         CW        = N_IN + 1;
  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       wait_cnt;
  logic [N_IN-1:0]  vec_q;
  logic [CW-1:0]    onset_q;
  logic [CW-1:0]    mm_q;
  logic [N_IN-1:0]  first_q;
  logic             first_valid_q;

  logic             accept;
  logic             sample_en;
  logic             last_vec;
  logic             mismatch;
  logic             busy_c;
  logic             done_c;

  // Start is honoured only from IDLE or DONE and takes priority over abort
  // there; abort only matters while a sweep is in flight.
  assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign sample_en = (state == ST_SAMPLE) && !bus.abort;
  assign last_vec  = &vec_q;
  assign mismatch  = bus.dut_y_i ^ bus.ref_y_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.abort)          state_nxt = ST_IDLE;
        else if (wait_cnt == 0) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort)     state_nxt = ST_IDLE;
        else if (last_vec) state_nxt = ST_DONE;
        else               state_nxt = ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      ST_SETTLE, ST_SAMPLE: busy_c = 1'b1;
      ST_DONE:              done_c = 1'b1;
      default:              ;
    endcase
  end

  // Vector, wait counter and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      vec_q         <= '0;
      onset_q       <= '0;
      mm_q          <= '0;
      first_q       <= '0;
      first_valid_q <= 1'b0;
    end else if (accept) begin
      wait_cnt      <= WAIT_LOAD;
      vec_q         <= '0;
      onset_q       <= '0;
      mm_q          <= '0;
      first_q       <= '0;
      first_valid_q <= 1'b0;
    end else if ((state == ST_SETTLE) && !bus.abort) begin
      if (wait_cnt != 0) wait_cnt <= wait_cnt - 4'd1;
    end else if (sample_en) begin
      onset_q <= onset_q + CW'(bus.dut_y_i);
      if (mismatch) begin
        mm_q <= mm_q + CW'(1);
        if (!first_valid_q) begin
          first_q       <= vec_q;
          first_valid_q <= 1'b1;
        end
      end
      // The all-ones vector is the last one; vec_o stays on it in DONE.
      if (!last_vec) begin
        vec_q    <= vec_q + N_IN'(1);
        wait_cnt <= WAIT_LOAD;
      end
    end
  end

  pla_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (sample_en),
    .data_in (bus.dut_y_i),
    .sig_out (bus.signature)
  );

  assign bus.vec_o          = vec_q;
  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.onset_cnt      = onset_q;
  assign bus.mismatch_cnt   = mm_q;
  assign bus.first_mm_vec   = first_q;
  assign bus.first_mm_valid = first_valid_q;

endmodule
